// File: rtl/lsm_pipe_pkg.sv
// rtl/lsm_pipe_pkg.sv - shared constants and beat type for the inter-stage pipeline register
//
// Default payload/PC geometry for lsm_pipe_stage and the {data, pc} beat record that
// the stage and its optional skid entry move around together.
// Optional feature macro used by the stage: PIPE_SKID_EN.
package lsm_pipe_pkg;

    localparam int LSM_DATA_W      = 21;
    localparam int LSM_PC_W        = 32;
    localparam int LSM_PC_INC      = 4;
    localparam int LSM_STALL_CNT_W = 16;

    // One pipeline beat: payload plus the already-incremented PC.
    typedef struct packed {
        logic [LSM_DATA_W-1:0] data;
        logic [LSM_PC_W-1:0]   pc;
    } lsm_beat_t;

endpackage

// File: rtl/lsm_skid_buf.sv
// rtl/lsm_skid_buf.sv - single-entry skid holding one beat while the stage output is blocked
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous reset, active-low
//   clr_i    in   drop the held beat (flush)
//   push_i   in   capture beat_i
//   pop_i    in   release the held beat
//   beat_i   in   beat to capture
//   valid_o  out  entry holds a beat
//   beat_o   out  held beat
// Only instantiated by lsm_pipe_stage when PIPE_SKID_EN is defined.
module lsm_skid_buf
    import lsm_pipe_pkg::*;
#(
    parameter type beat_t = lsm_beat_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clr_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  beat_t beat_i,
    output logic  valid_o,
    output beat_t beat_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            beat_o  <= '0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
        end else if (push_i) begin
            valid_o <= 1'b1;
            beat_o  <= beat_i;
        end else if (pop_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/lsm_pipe_stage.sv
// rtl/lsm_pipe_stage.sv - valid/ready pipeline register with PC increment, flush, stall and stall counter
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active-low
//   stall_i      in   hard hold: no capture, registers frozen
//   flush_i      in   kill held and incoming beats (wins over stall_i)
//   in_valid_i   in   upstream beat valid
//   in_ready_o   out  stage accepts this cycle
//   data_i       in   upstream payload
//   pc_i         in   upstream PC
//   out_valid_o  out  downstream beat valid
//   out_ready_i  in   downstream accepts
//   data_o       out  registered payload
//   pc_o         out  registered pc_i + PC_INC (wraps at PC_W)
//   stall_cnt_o  out  saturating count of stalled/backpressured cycles
// Macro PIPE_SKID_EN: adds a one-entry skid so in_ready_o depends on registered state only.
module lsm_pipe_stage
    import lsm_pipe_pkg::*;
#(
    parameter int DATA_W      = LSM_DATA_W,
    parameter int PC_W        = LSM_PC_W,
    parameter int PC_INC      = LSM_PC_INC,
    parameter int STALL_CNT_W = LSM_STALL_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      data_i,
    input  logic [PC_W-1:0]        pc_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_W-1:0]      data_o,
    output logic [PC_W-1:0]        pc_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    // Same layout as lsm_beat_t, resized to this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } beat_t;

    beat_t in_beat;
    beat_t out_q;
    beat_t out_d;
    logic  out_valid_q;
    logic  out_valid_d;
    logic  acc;
    logic  drn;

    assign in_beat.data = data_i;
    assign in_beat.pc   = pc_i + PC_W'(PC_INC);

    assign acc = in_valid_i && in_ready_o;
    assign drn = out_valid_q && out_ready_i;

`ifdef PIPE_SKID_EN
    logic  skid_valid;
    logic  skid_push;
    logic  skid_pop;
    beat_t skid_beat;

    assign in_ready_o = !stall_i && !skid_valid;
    // A beat accepted while the output is held parks in the skid.
    assign skid_push  = !flush_i && !stall_i && acc && out_valid_q && !out_ready_i;
    assign skid_pop   = !flush_i && !stall_i && drn && skid_valid;

    lsm_skid_buf #(
        .beat_t (beat_t)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .beat_i  (in_beat),
        .valid_o (skid_valid),
        .beat_o  (skid_beat)
    );
`else
    assign in_ready_o = !stall_i && (!out_valid_q || out_ready_i);
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (!stall_i) begin
`ifdef PIPE_SKID_EN
            // The skid is older than anything upstream, so it refills the output first.
            if (skid_valid && drn) begin
                out_d       = skid_beat;
                out_valid_d = 1'b1;
            end else
`endif
            if (acc && (!out_valid_q || drn)) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else if (drn) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Counts every cycle the stage is frozen or blocked downstream; flush does not clear it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if ((stall_i || (out_valid_q && !out_ready_i)) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign data_o      = out_q.data;
    assign pc_o        = out_q.pc;

endmodule
